wb_sram_bridge: RTL and testbench

//   Wishbone classic slave that maps two 512x32 dual-port OpenRAM macros into the user window.

---
 rtl/wb_sram_bridge_pkg.sv | 18 +
 rtl/wb_sram_bridge.sv | 175 +++++++++++++++++
 tb/tb_wb_sram_bridge.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sram_bridge_pkg.sv
// Shared types and geometry for the Wishbone-to-OpenRAM bridge.
// Two 512x32 macros sit behind one 4 KiB window; bit 11 picks the macro.
package wb_sram_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WSTB,
    RSTB,
    RWAIT,
    ACK
  } state_e;

  localparam int SRAM_AW  = 9;
  localparam int SRAM_DW  = 32;
  localparam int BANK_BIT = 11;
  localparam int WORD_LSB = 2;

endpackage

// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave that turns single accesses into one-cycle strobes on
// two dual-port OpenRAM macros (port 0 writes, port 1 reads) and returns ack/data.
module wb_sram_bridge
  import wb_sram_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned READ_LAT = 1
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic               o_csb0,
  output logic               o_csb0_1,
  output logic               o_web0,
  output logic               o_web0_1,
  output logic [3:0]         o_wmask0,
  output logic [3:0]         o_wmask0_1,
  output logic [SRAM_AW-1:0] o_waddr0,
  output logic [SRAM_AW-1:0] o_waddr0_1,
  output logic [SRAM_DW-1:0] o_din0,
  output logic [SRAM_DW-1:0] o_din0_1,
  output logic               o_csb1,
  output logic               o_csb1_1,
  output logic [SRAM_AW-1:0] o_addr1,
  output logic [SRAM_AW-1:0] o_addr1_1,
  input  logic [SRAM_DW-1:0] i_dout1,
  input  logic [SRAM_DW-1:0] i_dout1_1
);

  localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

  state_e             state_q, state_d;
  logic [1:0]         latCnt_q, latCnt_d;
  logic               bank_q, bank_d;
  logic               abort_q, abort_d;
  logic               ack_q, ack_d;
  logic [SRAM_DW-1:0] dat_q, dat_d;

  logic               hit, accept, abortNow, wrFire, rdFire, reqBank;
  logic [SRAM_AW-1:0] reqWord;
  logic [SRAM_DW-1:0] readData;
  logic               unused_adrLsb;

  assign unused_adrLsb = ^wbs_adr_i[1:0];
  assign reqBank  = wbs_adr_i[BANK_BIT];
  assign reqWord  = wbs_adr_i[WORD_LSB +: SRAM_AW];
  assign hit      = wbs_cyc_i & wbs_stb_i & ~ack_q & (wbs_adr_i[31:12] == BASE_ADR[31:12]);
  assign abortNow = abort_q | ~wbs_cyc_i;
  assign readData = bank_q ? i_dout1_1 : i_dout1;
  // An all-zero byte mask still gets acked, it just never touches the macro.
  assign wrFire   = accept & wbs_we_i & (wbs_sel_i != 4'b0000);
  assign rdFire   = accept & ~wbs_we_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      latCnt_q <= '0;
      bank_q   <= 1'b0;
      abort_q  <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      latCnt_q <= latCnt_d;
      bank_q   <= bank_d;
      abort_q  <= abort_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  // A dropped cyc is remembered so the macro access finishes but no ack is given.
  always_comb begin
    state_d  = state_q;
    latCnt_d = latCnt_q;
    bank_d   = bank_q;
    abort_d  = abort_q;
    ack_d    = 1'b0;
    dat_d    = '0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          accept   = 1'b1;
          bank_d   = reqBank;
          abort_d  = 1'b0;
          latCnt_d = '0;
          state_d  = wbs_we_i ? WSTB : RSTB;
        end
      end
      WSTB: begin
        abort_d = abortNow;
        ack_d   = ~abortNow;
        state_d = ACK;
      end
      RSTB: begin
        abort_d  = abortNow;
        latCnt_d = '0;
        state_d  = RWAIT;
      end
      RWAIT: begin
        abort_d = abortNow;
        if (latCnt_q == LAT_LAST) begin
          ack_d   = ~abortNow;
          dat_d   = abortNow ? '0 : readData;
          state_d = ACK;
        end else begin
          latCnt_d = latCnt_q + 2'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar b = 0; b < 2; b++) begin : gBank
    logic               wrHit, rdHit;
    logic               csb0_q, web0_q, csb1_q;
    logic [3:0]         wmask0_q;
    logic [SRAM_AW-1:0] waddr0_q, addr1_q;
    logic [SRAM_DW-1:0] din0_q;

    assign wrHit = wrFire & (reqBank == 1'(b));
    assign rdHit = rdFire & (reqBank == 1'(b));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        csb0_q   <= 1'b1;
        web0_q   <= 1'b1;
        csb1_q   <= 1'b1;
        wmask0_q <= '0;
        waddr0_q <= '0;
        din0_q   <= '0;
        addr1_q  <= '0;
      end else begin
        csb0_q <= ~wrHit;
        web0_q <= ~wrHit;
        csb1_q <= ~rdHit;
        if (wrHit) begin
          wmask0_q <= wbs_sel_i;
          waddr0_q <= reqWord;
          din0_q   <= wbs_dat_i;
        end
        if (rdHit) begin
          addr1_q <= reqWord;
        end
      end
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign o_csb0     = gBank[0].csb0_q;
  assign o_csb0_1   = gBank[1].csb0_q;
  assign o_web0     = gBank[0].web0_q;
  assign o_web0_1   = gBank[1].web0_q;
  assign o_wmask0   = gBank[0].wmask0_q;
  assign o_wmask0_1 = gBank[1].wmask0_q;
  assign o_waddr0   = gBank[0].waddr0_q;
  assign o_waddr0_1 = gBank[1].waddr0_q;
  assign o_din0     = gBank[0].din0_q;
  assign o_din0_1   = gBank[1].din0_q;
  assign o_csb1     = gBank[0].csb1_q;
  assign o_csb1_1   = gBank[1].csb1_q;
  assign o_addr1    = gBank[0].addr1_q;
  assign o_addr1_1  = gBank[1].addr1_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Bench for wb_sram_bridge: two behavioural macros, a word-level reference memory,
// a vector table, hand-written abort/reset sequences and randomized traffic.
module tb_wb_sram_bridge;

  localparam int READ_LAT = 1;
  localparam int NRAND    = 60;
  localparam logic [146:0] RESET_VEC = {1'b0, 32'h0, 4'b1111, 8'h00, 18'h0, 64'h0, 2'b11, 18'h0};

  logic        wb_clk_i, wb_rst_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        o_csb0, o_csb0_1, o_web0, o_web0_1, o_csb1, o_csb1_1;
  logic [3:0]  o_wmask0, o_wmask0_1;
  logic [8:0]  o_waddr0, o_waddr0_1, o_addr1, o_addr1_1;
  logic [31:0] o_din0, o_din0_1, i_dout1, i_dout1_1;

  logic [31:0] mem    [2][512];
  logic [31:0] refMem [2][512];
  logic [146:0] outVec;
  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    int ackCycle; int ackCnt;
    int wrCnt0; int wrCnt1; int rdCnt0; int rdCnt1;
    int wrFirst; int rdFirst; int datLeak;
    logic [8:0] wAddr; logic [8:0] rAddr;
    logic [3:0] wMask; logic wWeb;
    logic [31:0] wDin; logic [31:0] rdata;
  } acc_t;

  typedef struct {
    logic we; logic [31:0] adr; logic [31:0] dat; logic [3:0] sel;
    logic expAck; logic [31:0] expRd;
  } vec_t;

  wb_sram_bridge #(.BASE_ADR(32'h3000_0000), .READ_LAT(READ_LAT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .o_csb0(o_csb0), .o_csb0_1(o_csb0_1), .o_web0(o_web0), .o_web0_1(o_web0_1),
    .o_wmask0(o_wmask0), .o_wmask0_1(o_wmask0_1),
    .o_waddr0(o_waddr0), .o_waddr0_1(o_waddr0_1),
    .o_din0(o_din0), .o_din0_1(o_din0_1),
    .o_csb1(o_csb1), .o_csb1_1(o_csb1_1),
    .o_addr1(o_addr1), .o_addr1_1(o_addr1_1),
    .i_dout1(i_dout1), .i_dout1_1(i_dout1_1)
  );

  assign outVec = {wbs_ack_o, wbs_dat_o, o_csb0, o_csb0_1, o_web0, o_web0_1,
                   o_wmask0, o_wmask0_1, o_waddr0, o_waddr0_1, o_din0, o_din0_1,
                   o_csb1, o_csb1_1, o_addr1, o_addr1_1};

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [31:0] preload(int b, int i);
    if (b == 0 && i == 511) return 32'h1122_3344;
    if (b == 1 && i == 4)   return 32'h1234_5678;
    return 32'hA500_0000 | 32'(b << 16) | 32'(i);
  endfunction

  // Macro model: masked write on port 0, read data one cycle after the sampling edge.
  always @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 512; i++) mem[b][i] <= preload(b, i);
      i_dout1   <= '0;
      i_dout1_1 <= '0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (!o_csb0 && !o_web0 && o_wmask0[j])       mem[0][o_waddr0][8*j +: 8]   <= o_din0[8*j +: 8];
        if (!o_csb0_1 && !o_web0_1 && o_wmask0_1[j]) mem[1][o_waddr0_1][8*j +: 8] <= o_din0_1[8*j +: 8];
      end
      if (!o_csb1)   i_dout1   <= mem[0][o_addr1];
      if (!o_csb1_1) i_dout1_1 <= mem[1][o_addr1_1];
    end
  end

  task automatic refLoad();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 512; i++) refMem[b][i] = preload(b, i);
  endtask

  task automatic refWrite(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    for (int j = 0; j < 4; j++)
      if (sel[j]) refMem[adr[11]][adr[10:2]][8*j +: 8] = dat[8*j +: 8];
  endtask

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one access for 8 cycles and records every strobe, ack and dat_o seen.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input int abortAt, output acc_t r);
    r = '{default: 0};
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    for (int k = 1; k <= 8; k++) begin
      @(posedge wb_clk_i); #1;
      if (k == abortAt) begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
      if (!o_csb0 || !o_csb0_1) begin
        if (!o_csb0) r.wrCnt0++; else r.wrCnt1++;
        if (r.wrFirst == 0) begin
          r.wrFirst = k;
          r.wAddr = !o_csb0 ? o_waddr0 : o_waddr0_1;
          r.wMask = !o_csb0 ? o_wmask0 : o_wmask0_1;
          r.wDin  = !o_csb0 ? o_din0   : o_din0_1;
          r.wWeb  = !o_csb0 ? o_web0   : o_web0_1;
        end
      end
      if (!o_csb1 || !o_csb1_1) begin
        if (!o_csb1) r.rdCnt0++; else r.rdCnt1++;
        if (r.rdFirst == 0) begin
          r.rdFirst = k;
          r.rAddr = !o_csb1 ? o_addr1 : o_addr1_1;
        end
      end
      if (wbs_ack_o) begin
        r.ackCnt++;
        if (r.ackCycle == 0) begin r.ackCycle = k; r.rdata = wbs_dat_o; end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      end else if (wbs_dat_o != 32'h0) begin
        r.datLeak++;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  task automatic checkAccess(input string name, input acc_t r, input logic we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel, input logic expAck,
                             input logic [31:0] expRd);
    logic b, expW, expR;
    logic [8:0] w;
    b = adr[11]; w = adr[10:2];
    expW = expAck && we && (sel != 4'b0000);
    expR = expAck && !we;
    checkOutput({name, ".ackCycle"}, r.ackCycle, !expAck ? 0 : (we ? 2 : READ_LAT + 2));
    checkOutput({name, ".ackCnt"}, r.ackCnt, {159'b0, expAck});
    checkOutput({name, ".wrCnt"}, {8'(r.wrCnt0), 8'(r.wrCnt1)}, {8'(expW && !b), 8'(expW && b)});
    checkOutput({name, ".rdCnt"}, {8'(r.rdCnt0), 8'(r.rdCnt1)}, {8'(expR && !b), 8'(expR && b)});
    if (expW)
      checkOutput({name, ".wrStrobe"}, {8'(r.wrFirst), r.wWeb, r.wAddr, r.wMask, r.wDin},
                  {8'd1, 1'b0, w, sel, dat});
    if (expR)
      checkOutput({name, ".rdData"}, {8'(r.rdFirst), r.rAddr, r.rdata}, {8'd1, w, expRd});
    checkOutput({name, ".datIdleZero"}, r.datLeak, 0);
  endtask

  initial begin
    vec_t vecs [11];
    acc_t r;
    logic rwe, rb, inWin;
    logic [3:0] rsel;
    logic [31:0] radr, rdat;
    int rw;

    vecs[0]  = '{1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0};
    vecs[1]  = '{1'b0, 32'h3000_0810, 32'h0,         4'hF, 1'b1, 32'h1234_5678};
    vecs[2]  = '{1'b1, 32'h3000_07FC, 32'hAABB_CCDD, 4'h4, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h3000_07FC, 32'h0,         4'hF, 1'b1, 32'h11BB_3344};
    vecs[4]  = '{1'b0, 32'h3000_1000, 32'h0,         4'hF, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h3000_0020, 32'h1234_5678, 4'h0, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'h3000_0020, 32'h0,         4'hF, 1'b1, 32'hA500_0008};
    vecs[7]  = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 1'b1, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 32'h3000_0C00, 32'hCAFE_F00D, 4'h3, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 32'h3000_0C02, 32'h0,         4'hF, 1'b1, 32'hA501_F00D};
    vecs[10] = '{1'b1, 32'h2000_0010, 32'h5555_AAAA, 4'hF, 1'b0, 32'h0};

    wb_rst_i = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
    refLoad();
    repeat (3) @(posedge wb_clk_i);
    #1;
    checkOutput("resetState", outVec, RESET_VEC);
    wb_rst_i = 1'b0;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, 0, r);
      checkAccess($sformatf("vec%0d", i), r, vecs[i].we, vecs[i].adr, vecs[i].dat,
                  vecs[i].sel, vecs[i].expAck, vecs[i].expRd);
      if (vecs[i].we && vecs[i].expAck) refWrite(vecs[i].adr, vecs[i].dat, vecs[i].sel);
    end

    // Read dropped in its strobe cycle: port-1 pulse still happens, ack never does.
    applyStimulus(1'b0, 32'h3000_0814, 32'h0, 4'hF, 1, r);
    checkOutput("abort.rdStrobe", {8'(r.rdCnt1), 8'(r.rdFirst), r.rAddr}, {8'd1, 8'd1, 9'd5});
    checkOutput("abort.noAck", r.ackCnt, 0);
    applyStimulus(1'b1, 32'h3000_0814, 32'h0BAD_F00D, 4'hF, 0, r);
    checkAccess("afterAbortWr", r, 1'b1, 32'h3000_0814, 32'h0BAD_F00D, 4'hF, 1'b1, 32'h0);
    refWrite(32'h3000_0814, 32'h0BAD_F00D, 4'hF);
    applyStimulus(1'b0, 32'h3000_0814, 32'h0, 4'hF, 0, r);
    checkAccess("afterAbortRd", r, 1'b0, 32'h3000_0814, 32'h0, 4'hF, 1'b1, 32'h0BAD_F00D);

    // Reset lands while the read sits in its wait state.
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h3000_0810; wbs_sel_i = 4'hF;
    repeat (2) begin @(posedge wb_clk_i); #1; end
    wb_rst_i = 1'b1;
    #1;
    checkOutput("resetMidRead", outVec, RESET_VEC);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    refLoad();
    applyStimulus(1'b0, 32'h3000_0810, 32'h0, 4'hF, 0, r);
    checkAccess("readAfterReset", r, 1'b0, 32'h3000_0810, 32'h0, 4'hF, 1'b1, 32'h1234_5678);

    for (int n = 0; n < NRAND; n++) begin
      inWin = ($urandom_range(0, 9) != 0);
      rwe   = 1'($urandom_range(0, 1));
      rb    = 1'($urandom_range(0, 1));
      rw    = $urandom_range(0, 11);
      if (rw >= 8) rw = rw + 500;
      rsel  = 4'($urandom_range(0, 15));
      rdat  = $urandom;
      if (inWin) radr = 32'h3000_0000 | 32'(rb) << 11 | 32'(rw) << 2 | 32'($urandom_range(0, 3));
      else       radr = 32'h3001_0000 | ($urandom & 32'h0000_0FFF);
      applyStimulus(rwe, radr, rdat, rsel, 0, r);
      checkAccess($sformatf("rand%0d", n), r, rwe, radr, rdat, rsel, inWin,
                  refMem[radr[11]][radr[10:2]]);
      if (inWin && rwe) refWrite(radr, rdat, rsel);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
